// File: rtl/addrgen_2_a.sv
// addrgen_2_a: write-side address generator for frame RAM2 port A.
// Takes a valid/ready pixel stream with a start-of-frame marker and writes
// one full frame (addresses 0..FRAME_PIXELS-1), then pulses frame_done.
module addrgen_2_a #(
  parameter int FRAME_PIXELS = 153600,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 8,
  parameter bit CONTINUOUS   = 1'b0
) (
  input  logic              clk,
  input  logic              Reset_Main,
  input  logic              arm,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] addr_2a,
  output logic [DATA_W-1:0] din_2a,
  output logic              we_2a,
  output logic              en_ram2a,
  output logic              busy,
  output logic              frame_done,
  output logic              sof_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam bit                ONE_PIXEL = (FRAME_PIXELS == 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              wr_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              err_nxt;
  logic              accept;

  // The block only listens to the source while a frame is being captured.
  assign pix_ready = (state == ARMED) || (state == WRITE);
  assign busy      = pix_ready;
  assign accept    = pix_valid & pix_ready;
  assign en_ram2a  = we_2a;

  // Next-state, counter and write-request decode; a start-of-frame pixel
  // always restarts the frame at address 0, even mid-frame.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_nxt      = 1'b0;
    wr_addr_nxt = cnt;
    err_nxt     = sof_err;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      ARMED: begin
        if (accept && pix_sof) begin
          wr_nxt      = 1'b1;
          wr_addr_nxt = '0;
          if (ONE_PIXEL) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WRITE;
            cnt_nxt   = ONE;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          wr_nxt = 1'b1;
          if (pix_sof) begin
            err_nxt     = 1'b1;
            wr_addr_nxt = '0;
            if (ONE_PIXEL) begin
              state_nxt = DONE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = ONE;
            end
          end else if (cnt == LAST_ADDR) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      DONE: begin
        state_nxt = CONTINUOUS ? ARMED : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered RAM-port outputs; address and data hold
  // their last value between writes.
  always_ff @(posedge clk) begin
    if (Reset_Main) begin
      state      <= IDLE;
      cnt        <= '0;
      we_2a      <= 1'b0;
      addr_2a    <= '0;
      din_2a     <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      we_2a      <= wr_nxt;
      frame_done <= (state == DONE);
      sof_err    <= err_nxt;
      if (wr_nxt) begin
        addr_2a <= wr_addr_nxt;
        din_2a  <= pix_data;
      end
    end
  end

endmodule

// File: tb/tb_addrgen_2_a.sv
// tb_addrgen_2_a: self-checking bench for addrgen_2_a. Two instances share the
// stimulus: an 8-pixel single-shot one and a 4-pixel continuous one.
module tb_addrgen_2_a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset_Main;
  logic       arm;
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] pix_data;

  logic        ready0, busy0, we0, en0, done0, err0;
  logic [17:0] addr0;
  logic [7:0]  din0;
  logic        ready1, busy1, we1, en1, done1, err1;
  logic [17:0] addr1;
  logic [7:0]  din1;

  addrgen_2_a #(.FRAME_PIXELS(8), .ADDR_W(18), .DATA_W(8), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .Reset_Main(Reset_Main), .arm(arm), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(ready0), .addr_2a(addr0),
    .din_2a(din0), .we_2a(we0), .en_ram2a(en0), .busy(busy0),
    .frame_done(done0), .sof_err(err0)
  );

  addrgen_2_a #(.FRAME_PIXELS(4), .ADDR_W(18), .DATA_W(8), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .Reset_Main(Reset_Main), .arm(arm), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(ready1), .addr_2a(addr1),
    .din_2a(din1), .we_2a(we1), .en_ram2a(en1), .busy(busy1),
    .frame_done(done1), .sof_err(err1)
  );

  wire [31:0] obs_vec [2];
  assign obs_vec[0] = {ready0, busy0, we0, en0, done0, err0, addr0, din0};
  assign obs_vec[1] = {ready1, busy1, we1, en1, done1, err1, addr1, din1};

  int errors = 0;
  int checks = 0;

  // Reference model: frame-level view of the capture (listening, position in
  // the frame, one dead cycle after the last pixel) per instance.
  int          fp   [2] = '{8, 4};
  bit          cont [2] = '{1'b0, 1'b1};
  bit          capt [2];
  bit          gap  [2];
  int          pos  [2];
  logic        m_we [2];
  logic        m_done [2];
  logic        m_err  [2];
  logic [17:0] m_addr [2];
  logic [7:0]  m_din  [2];
  logic [31:0] exp_vec [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (Reset_Main) begin
        capt[i] = 1'b0; gap[i] = 1'b0; pos[i] = -1;
        m_we[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
        m_addr[i] = '0; m_din[i] = '0;
      end else begin
        m_we[i]   = 1'b0;
        m_done[i] = 1'b0;
        if (gap[i]) begin
          gap[i]    = 1'b0;
          m_done[i] = 1'b1;
          capt[i]   = cont[i];
          pos[i]    = -1;
        end else if (!capt[i]) begin
          if (arm) begin
            capt[i]  = 1'b1;
            pos[i]   = -1;
            m_err[i] = 1'b0;
          end
        end else if (pix_valid) begin
          if (pix_sof) begin
            if (pos[i] >= 0) m_err[i] = 1'b1;
            pos[i] = 0;
          end
          if (pos[i] >= 0) begin
            m_we[i]   = 1'b1;
            m_addr[i] = 18'(pos[i]);
            m_din[i]  = pix_data;
            pos[i]    = pos[i] + 1;
            if (pos[i] == fp[i]) gap[i] = 1'b1;
          end
        end
      end
      exp_vec[i] = {capt[i] & ~gap[i], capt[i] & ~gap[i], m_we[i], m_we[i],
                    m_done[i], m_err[i], m_addr[i], m_din[i]};
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, and return at
  // the following falling edge where outputs are sampled.
  task automatic tick(input logic r, input logic a, input logic v,
                      input logic s, input logic [7:0] d);
    Reset_Main = r; arm = a; pix_valid = v; pix_sof = s; pix_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 0, 1, 1, 8'h55);
    tick(0, 0, 1, 0, 8'h56);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec[i] !== exp_vec[i]) begin
        errors++;
        $display("[TB] FAIL reset_prestream dut%0d obs=%h exp=%h", i, obs_vec[i], exp_vec[i]);
      end
    end
    tick(1, 0, 1, 0, 8'h57);
    tick(1, 0, 1, 0, 8'h58);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_zero dut%0d obs=%h exp=%h", i, obs_vec[i], 32'h0);
      end
    end
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 0, 1, 1, 8'h11);
    checks++;
    if ({we0, en0, addr0, din0} !== {1'b1, 1'b1, 18'h0, 8'h11}) begin
      errors++;
      $display("[TB] FAIL reset_first_write obs=%b/%h/%h exp=1/00000/11", we0, addr0, din0);
    end
  endtask

  task automatic test_full_frame();
    int pulses;
    int writes;
    pulses = 0; writes = 0;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    for (int p = 0; p < 11; p++) begin
      if (p < 8) tick(0, 0, 1, (p == 0), 8'(p));
      else       tick(0, 0, 0, 0, 8'hEE);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL full_frame dut%0d step%0d obs=%h exp=%h", i, p, obs_vec[i], exp_vec[i]);
        end
      end
      if (we0) begin
        checks++;
        if ({addr0, din0} !== {18'(writes), 8'(writes)}) begin
          errors++;
          $display("[TB] FAIL full_frame_seq obs=%h/%h exp=%h/%h", addr0, din0, writes, writes);
        end
        writes++;
      end
      if (done0) pulses++;
    end
    checks++;
    if (pulses !== 1 || writes !== 8) begin
      errors++;
      $display("[TB] FAIL full_frame_count pulses=%0d writes=%0d exp 1/8", pulses, writes);
    end
    checks++;
    if ({ready0, busy0} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL full_frame_idle obs=%b exp=00", {ready0, busy0});
    end
  endtask

  task automatic test_pre_sof();
    logic [7:0] stim [11] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                              8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
    bit first_seen;
    first_seen = 1'b0;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    for (int p = 0; p < 11; p++) begin
      tick(0, 0, 1, (p == 2), stim[p]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL pre_sof dut%0d step%0d obs=%h exp=%h", i, p, obs_vec[i], exp_vec[i]);
        end
      end
      if (we0 && !first_seen) begin
        first_seen = 1'b1;
        checks++;
        if ({addr0, din0} !== {18'h0, 8'hB0} || p !== 2) begin
          errors++;
          $display("[TB] FAIL pre_sof_first step%0d obs=%h/%h exp=00000/b0 at step2", p, addr0, din0);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit prev_v;
    bit v;
    prev_v = 1'b1;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 0, 1, 1, 8'h40);
    for (int p = 0; p < 20; p++) begin
      v = ((p % 4) == 0) || ((p % 4) == 3);
      prev_v = v;
      tick(0, 0, v, 0, 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL stall dut%0d step%0d obs=%h exp=%h", i, p, obs_vec[i], exp_vec[i]);
        end
      end
      if (!prev_v) begin
        checks++;
        if (we0 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_we step%0d obs=%b exp=0", p, we0);
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    int pulses;
    pulses = 0;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    for (int p = 0; p < 13; p++) begin
      if (p < 11) tick(0, 0, 1, (p == 0) || (p == 3), 8'(8'h60 + p));
      else        tick(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL mid_sof dut%0d step%0d obs=%h exp=%h", i, p, obs_vec[i], exp_vec[i]);
        end
      end
      if (p == 3) begin
        checks++;
        if ({we0, addr0, din0} !== {1'b1, 18'h0, 8'h63}) begin
          errors++;
          $display("[TB] FAIL mid_sof_resync obs=%b/%h/%h exp=1/00000/63", we0, addr0, din0);
        end
      end
      if (done0) pulses++;
    end
    checks++;
    if (err0 !== 1'b1 || pulses !== 1) begin
      errors++;
      $display("[TB] FAIL mid_sof_sticky err=%b pulses=%0d exp 1/1", err0, pulses);
    end
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);
    checks++;
    if (err0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_sof_clear obs=%b exp=0", err0);
    end
  endtask

  task automatic test_continuous();
    int k;
    int pulses;
    int writes;
    k = 0; pulses = 0; writes = 0;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      if (ready1) begin
        tick(0, 0, 1, (k % 4) == 0, 8'(8'hC0 + k));
        k++;
      end else begin
        tick(0, 0, 1, (k % 4) == 0, 8'(8'hC0 + k));
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL continuous dut%0d cyc%0d obs=%h exp=%h", i, cyc, obs_vec[i], exp_vec[i]);
        end
      end
      if (we1) begin
        checks++;
        if ({addr1, din1} !== {18'(writes % 4), 8'(8'hC0 + writes)}) begin
          errors++;
          $display("[TB] FAIL continuous_seq obs=%h/%h exp=%h/%h", addr1, din1, writes % 4, 8'hC0 + writes);
        end
        writes++;
      end
      if (done1) pulses++;
    end
    checks++;
    if (k !== 8) begin
      errors++;
      $display("[TB] FAIL continuous_timeout accepted=%0d exp=8", k);
    end
    for (int p = 0; p < 3; p++) begin
      tick(0, 0, 0, 0, 8'h00);
      if (done1) pulses++;
    end
    checks++;
    if (pulses !== 2 || writes !== 8 || ready1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL continuous_count pulses=%0d writes=%0d ready=%b exp 2/8/1", pulses, writes, ready1);
    end
  endtask

  task automatic test_random();
    tick(1, 0, 0, 0, 8'h00);
    for (int p = 0; p < 400; p++) begin
      tick(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
           ($urandom % 6) == 0, 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec[i] !== exp_vec[i]) begin
          errors++;
          $display("[TB] FAIL random dut%0d step%0d obs=%h exp=%h", i, p, obs_vec[i], exp_vec[i]);
        end
      end
    end
  endtask

  initial begin
    Reset_Main = 1'b1; arm = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_pre_sof();
    test_stall();
    test_mid_sof();
    test_continuous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addrgen_2_a.md
Name: addrgen_2_a

Overview:
- Write-side address generator for frame RAM2 port A; the partner of the port-B display reader.
- Accepts a pixel stream with a valid/ready handshake and start-of-frame marker.
- Writes one full frame (default 153600 pixels, addresses 0..153599) into RAM2 port A, then flags completion.
- Sits between the pixel source (capture/processing path) and the dual-port frame RAM.

Parameters:
FRAME_PIXELS, 153600, pixels per frame; last address = FRAME_PIXELS-1
ADDR_W, 18, RAM2 address width
DATA_W, 8, pixel data width
CONTINUOUS, 0, 1 = re-arm automatically after each frame; 0 = return to IDLE

Ports:
clk  in  1  system clock, all logic on rising edge
Reset_Main  in  1  synchronous active-high reset
arm  in  1  single-cycle request to capture next frame
pix_valid  in  1  source has pixel on pix_data
pix_sof  in  1  qualifies pixel as first of frame; meaningful only with pix_valid
pix_data  in  DATA_W  pixel value
pix_ready  out  1  block accepts pixel this cycle
addr_2a  out  ADDR_W  RAM2 port-A address
din_2a  out  DATA_W  RAM2 port-A write data
we_2a  out  1  RAM2 port-A write enable
en_ram2a  out  1  RAM2 port-A enable, equal to we_2a
busy  out  1  high in ARMED or WRITE
frame_done  out  1  one-cycle pulse after last pixel written
sof_err  out  1  sticky: pix_sof seen mid-frame; cleared by reset or arm

Behaviour:
- Reset (sync, Reset_Main=1 at clk edge):
  - State = IDLE; pixel counter = 0.
  - Outputs addr_2a=0, din_2a=0, we_2a=0, en_ram2a=0, pix_ready=0, busy=0, frame_done=0, sof_err=0.
  - Reset mid-frame abandons the frame; no further writes.
- Accept = pix_valid & pix_ready.
- pix_ready is combinational from state: 1 in ARMED and WRITE, 0 in IDLE and DONE.
- States:
  - IDLE: arm -> ARMED.
  - ARMED:
    - Accept with pix_sof -> write pixel at address 0, counter=1, go to WRITE. With FRAME_PIXELS=1, go straight to DONE.
    - Accept without pix_sof -> pixel consumed and discarded, no write.
  - WRITE:
    - Accept without pix_sof -> write at counter, counter+1.
    - Accept with counter==FRAME_PIXELS-1 -> final write, go to DONE.
    - Accept with pix_sof -> set sof_err, write pixel at address 0, counter=1 (resync), stay in WRITE.
  - DONE: frame_done=1 for exactly this one cycle. Next state is ARMED if CONTINUOUS=1, else IDLE.
- Write latency: registered outputs. Pixel accepted at edge N appears on addr_2a/din_2a with we_2a=1 in the cycle after edge N. we_2a=0 in any cycle not following an accept; addr_2a/din_2a hold their last value.
- frame_done is asserted the cycle after the final write cycle. The final write (we_2a=1, addr_2a=FRAME_PIXELS-1) and frame_done are never in the same cycle.
- Counter never exceeds FRAME_PIXELS-1 and wraps only via the DONE/ARMED path.
- arm:
  - Ignored in ARMED, WRITE and DONE.
  - arm in IDLE clears sof_err.
  - arm asserted during DONE with CONTINUOUS=0 is ignored; re-arm after IDLE.
- Stalls: pix_valid low mid-frame pauses; counter and state hold indefinitely.
- busy = (state==ARMED) | (state==WRITE).

Test Plan:
- Reset: hold Reset_Main 2 cycles mid-stream -> next cycle all outputs 0, state IDLE, pix_ready=0. Then arm, sof pixel 0x11 -> we_2a=1, addr_2a=0, din_2a=0x11.
- Full frame (FRAME_PIXELS=8, CONTINUOUS=0): arm, 8 back-to-back pixels 0x00..0x07 with sof on the first -> writes addr 0..7 with data 0..7 on consecutive cycles, then frame_done=1 one cycle, then pix_ready=0, busy=0.
- Pre-sof discard: arm, pixels 0xA0, 0xA1 without sof, then 0xB0 with sof -> no writes for 0xA0/0xA1; first write is addr 0 data 0xB0.
- Stall: toggle pix_valid 1,0,0,1 mid-frame -> addresses increment only on accepted cycles, no gaps or duplicates, we_2a=0 in stall cycles.
- Mid-frame sof (FRAME_PIXELS=8): sof again at pixel 3 -> sof_err=1 sticky, that pixel written at addr 0, frame completes after 8 more pixels. arm in IDLE clears sof_err.
- Continuous (CONTINUOUS=1, FRAME_PIXELS=4): two frames back-to-back -> frame_done pulses twice, second frame starts at addr 0, no arm needed. Default-parameter run writes final address 153599 (18'h257FF) before frame_done.
